// File: rtl/shared_eva_xlate_arb_pkg.sv
// Shared definitions for the shared-EVA translation arbiter: endpoint address
// geometry, the FSM state type and the registered result record.
package shared_eva_xlate_arb_pkg;

  // Width of the destination tile's local word address.
  localparam int epa_word_addr_width_gp    = 16;
  // Largest stripe value that still leaves a legal local-offset field.
  localparam int max_local_offset_width_gp = 12;

  // Default geometry; the result record below is sized from these, so the
  // top-level parameters are expected to stay at these values.
  localparam int x_cord_width_gp = 6;
  localparam int y_cord_width_gp = 5;
  localparam int num_req_gp      = 4;
  localparam int id_width_gp     = (num_req_gp > 1) ? $clog2(num_req_gp) : 1;

  // Config-update sequencing: normal arbitration, wait for the output stage
  // to empty, then swap in the new stripe value.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } xlate_state_e;

  // One translated request as held in the output register.
  typedef struct packed {
    logic [x_cord_width_gp-1:0]        x;
    logic [y_cord_width_gp-1:0]        y;
    logic [epa_word_addr_width_gp-1:0] addr;
    logic [id_width_gp-1:0]            id;
    logic                              err;
  } shared_xlate_s;

endpackage

// File: rtl/shared_eva_xlate_arb_hash.sv
// Shared-EVA striping datapath. The low hash_i bits of the EVA are the word
// offset inside a stripe, the next tg_x/tg_y bits select the tile inside the
// tile group, and the remaining high bits are stacked above the offset to
// form the local word address. A stripe wider than the local offset field is
// flagged as an error and all coordinates are forced to zero.
module shared_eva_xlate_arb_hash
  import shared_eva_xlate_arb_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int x_cord_width_p = 6,
  parameter int y_cord_width_p = 5,
  parameter int tg_x_width_p   = 2,
  parameter int tg_y_width_p   = 2,
  parameter int hash_width_p   = 4
) (
  input  logic                              en_i,
  input  logic [hash_width_p-1:0]           hash_i,
  input  logic [width_p-1:0]                shared_eva_i,
  output logic [x_cord_width_p-1:0]         x_o,
  output logic [y_cord_width_p-1:0]         y_o,
  output logic [epa_word_addr_width_gp-1:0] addr_o,
  output logic                              err_o
);

  localparam logic [hash_width_p-1:0] max_off_lp  = hash_width_p'(max_local_offset_width_gp);
  localparam logic [width_p-1:0]      tgx_mask_lp = width_p'((64'd1 << tg_x_width_p) - 64'd1);
  localparam logic [width_p-1:0]      tgy_mask_lp = width_p'((64'd1 << tg_y_width_p) - 64'd1);

  logic [width_p-1:0] off_mask_s;
  logic               err_s;

  // Field extraction from the EVA for the current stripe width.
  always_comb begin
    off_mask_s = ~({width_p{1'b1}} << hash_i);
    err_s      = (hash_i > max_off_lp);
    err_o      = en_i & err_s;
    if (en_i && !err_s) begin
      x_o    = x_cord_width_p'((shared_eva_i >> hash_i) & tgx_mask_lp);
      y_o    = y_cord_width_p'((shared_eva_i >> (hash_i + tg_x_width_p)) & tgy_mask_lp);
      addr_o = epa_word_addr_width_gp'(
                 ((shared_eva_i >> (hash_i + tg_x_width_p + tg_y_width_p)) << hash_i)
                 | (shared_eva_i & off_mask_s));
    end else begin
      x_o    = '0;
      y_o    = '0;
      addr_o = '0;
    end
  end

endmodule

// File: rtl/shared_eva_xlate_arb.sv
// Round-robin arbiter placing shared-EVA translation requests from several
// requesters onto one striping datapath. Owns the stripe config register and
// registers each result behind a valid/ready handshake toward the packet
// formatter. A config write drains the output stage before the new stripe
// value takes effect, so no result is ever produced with a half-updated hash.
module shared_eva_xlate_arb
  import shared_eva_xlate_arb_pkg::*;
#(
  parameter int num_req_p      = num_req_gp,
  parameter int width_p        = 32,
  parameter int x_cord_width_p = x_cord_width_gp,
  parameter int y_cord_width_p = y_cord_width_gp,
  parameter int tg_x_width_p   = 2,
  parameter int tg_y_width_p   = 2,
  parameter int hash_width_p   = 4,
  // Derived; leave at default.
  parameter int id_width_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*width_p-1:0]      req_eva_i,
  output logic [num_req_p-1:0]              req_ready_o,
  input  logic                              cfg_we_i,
  input  logic [hash_width_p-1:0]           cfg_hash_i,
  output logic                              cfg_done_o,
  output logic                              out_v_o,
  input  logic                              out_ready_i,
  output logic [x_cord_width_p-1:0]         out_x_o,
  output logic [y_cord_width_p-1:0]         out_y_o,
  output logic [epa_word_addr_width_gp-1:0] out_addr_o,
  output logic [id_width_lp-1:0]            out_id_o,
  output logic                              out_err_o
);

  xlate_state_e              state_q, state_d;
  logic [hash_width_p-1:0]   hash_q, hash_d;
  logic [hash_width_p-1:0]   pend_q, pend_d;
  logic [id_width_lp-1:0]    rr_q, rr_d;
  shared_xlate_s             out_q, out_d;
  logic                      out_v_q, out_v_d;
  logic                      cfg_done_q, cfg_done_d;

  logic                      load_en_s;
  logic                      grant_v_s;
  logic [id_width_lp-1:0]    grant_id_s;
  logic [id_width_lp-1:0]    idx_s;
  logic [num_req_p-1:0]      ready_s;
  logic                      accept_s;
  logic [width_p-1:0]        win_eva_s;
  logic [x_cord_width_p-1:0] xl_x_s;
  logic [y_cord_width_p-1:0] xl_y_s;
  logic [epa_word_addr_width_gp-1:0] xl_addr_s;
  logic                      xl_err_s;

  // Output stage can take a new entry when empty or emptying this cycle.
  assign load_en_s = ~out_v_q | out_ready_i;

  // Round-robin scan starting at rr_q; the first valid requester wins.
  // Requesters must not make req_v_i depend on req_ready_o.
  always_comb begin
    grant_v_s  = 1'b0;
    grant_id_s = '0;
    idx_s      = '0;
    for (int off = 0; off < num_req_p; off++) begin
      idx_s = id_width_lp'((int'(rr_q) + off) % num_req_p);
      if (!grant_v_s && req_v_i[idx_s]) begin
        grant_v_s  = 1'b1;
        grant_id_s = idx_s;
      end else begin
        grant_v_s  = grant_v_s;
      end
    end
  end

  assign win_eva_s = req_eva_i[grant_id_s*width_p +: width_p];

  shared_eva_xlate_arb_hash #(
    .width_p        (width_p),
    .x_cord_width_p (x_cord_width_p),
    .y_cord_width_p (y_cord_width_p),
    .tg_x_width_p   (tg_x_width_p),
    .tg_y_width_p   (tg_y_width_p),
    .hash_width_p   (hash_width_p)
  ) u_hash (
    .en_i         (1'b1),
    .hash_i       (hash_q),
    .shared_eva_i (win_eva_s),
    .x_o          (xl_x_s),
    .y_o          (xl_y_s),
    .addr_o       (xl_addr_s),
    .err_o        (xl_err_s)
  );

  // Config FSM next state, grant gating and stripe register update.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    hash_d     = hash_q;
    ready_s    = '0;
    cfg_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (grant_v_s && load_en_s) begin
          ready_s[grant_id_s] = 1'b1;
        end else begin
          ready_s = '0;
        end
        if (cfg_we_i) begin
          pend_d  = cfg_hash_i;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (load_en_s) begin
          state_d    = ST_COMMIT;
          cfg_done_d = 1'b1;
        end else begin
          state_d    = ST_DRAIN;
        end
      end
      ST_COMMIT: begin
        hash_d  = pend_q;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign accept_s    = |(req_v_i & ready_s);
  assign req_ready_o = ready_s;

  // Round-robin pointer advances past the winner only on an accepted request.
  always_comb begin
    rr_d = rr_q;
    if (accept_s) begin
      if (int'(grant_id_s) == num_req_p - 1) begin
        rr_d = '0;
      end else begin
        rr_d = grant_id_s + id_width_lp'(1);
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // Single-entry output register: load on accept, clear when drained.
  always_comb begin
    out_v_d = out_v_q;
    out_d   = out_q;
    if (accept_s) begin
      out_v_d    = 1'b1;
      out_d.x    = xl_x_s;
      out_d.y    = xl_y_s;
      out_d.addr = xl_addr_s;
      out_d.id   = grant_id_s;
      out_d.err  = xl_err_s;
    end else if (out_ready_i) begin
      out_v_d = 1'b0;
    end else begin
      out_v_d = out_v_q;
    end
  end

  // State, config and output registers; reset discards any in-flight work.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_RUN;
      hash_q     <= '0;
      pend_q     <= '0;
      rr_q       <= '0;
      out_q      <= '0;
      out_v_q    <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hash_q     <= hash_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      out_q      <= out_d;
      out_v_q    <= out_v_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  assign cfg_done_o = cfg_done_q;
  assign out_v_o    = out_v_q;
  assign out_x_o    = out_q.x;
  assign out_y_o    = out_q.y;
  assign out_addr_o = out_q.addr;
  assign out_id_o   = out_q.id;
  assign out_err_o  = out_q.err;

endmodule
